// File: rtl/dds_wave_gen_if.sv
// Configuration channel of the DDS waveform generator: a valid/ready
// handshake carrying frequency tuning word, phase offset and wave select.
interface dds_wave_gen_if #(
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 10
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [PHASE_W-1:0] cfg_freq;
  logic [ADDR_W-1:0]  cfg_phase;
  logic [1:0]         cfg_wave;

  modport master (
    output cfg_valid, cfg_freq, cfg_phase, cfg_wave,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_freq, cfg_phase, cfg_wave,
    output cfg_ready
  );
endinterface

// File: rtl/dds_wave_gen.sv
// Direct digital synthesis waveform generator. A phase accumulator drives an
// external synchronous sine ROM; a three-stage pipeline (address, ROM read,
// output) shapes sine, square, triangle or sawtooth samples and flags the
// sample at which the accumulator wrapped.
module dds_wave_gen #(
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  dds_wave_gen_if.slave     cfg,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] wave_data,
  output logic              wave_valid,
  output logic              cycle_tick
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SAW    = 2'd3
  } wave_t;

  state_t             state, state_nxt;
  logic               flush_cnt;
  logic               rst_done;
  logic               cfg_fire;
  logic               issue;

  logic [PHASE_W-1:0] freq;
  logic [ADDR_W-1:0]  phase;
  wave_t              wave_sel;

  logic [PHASE_W-1:0] acc;
  logic [PHASE_W:0]   acc_sum;

  // Stage 0 travels with rom_addr, stage 1 with the ROM read.
  wave_t              wave0, wave1;
  logic               valid0, valid1;
  logic               wrap0, wrap1;
  logic [ADDR_W-1:0]  addr1;

  logic [ADDR_W-1:0]  tri_full;
  logic [DATA_W-1:0]  shaped;

  // State register plus the two-cycle FLUSH counter.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      flush_cnt <= 1'b0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= (state == FLUSH) && (state_nxt == FLUSH);
    end
  end

  // Next-state logic: FLUSH drains the pipeline for two cycles unless en returns.
  // NOTE: state_nxt is defaulted before the case so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (!en) state_nxt = FLUSH;
      FLUSH:   if (en) state_nxt = RUN;
               else if (flush_cnt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Holds cfg_ready low while reset is asserted and until the first clock after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_done <= 1'b0;
    else        rst_done <= 1'b1;
  end

  assign cfg.cfg_ready = rst_done && (state != FLUSH);
  assign cfg_fire      = cfg.cfg_valid && cfg.cfg_ready;

  // An address is issued on every edge that lands in RUN, so rom_addr carries a
  // live sample exactly while state is RUN.
  assign issue   = (state_nxt == RUN);
  assign acc_sum = {1'b0, acc} + {1'b0, freq};

  // Configuration capture; the accumulator is left untouched on reconfiguration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq     <= '0;
      phase    <= '0;
      wave_sel <= WAVE_SINE;
    end else if (cfg_fire) begin
      freq     <= cfg.cfg_freq;
      phase    <= cfg.cfg_phase;
      wave_sel <= wave_t'(cfg.cfg_wave);
    end
  end

  // Stage 0: accumulator step and ROM address issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      rom_addr <= '0;
      wave0    <= WAVE_SINE;
      valid0   <= 1'b0;
      wrap0    <= 1'b0;
    end else begin
      valid0 <= issue;
      wrap0  <= issue && acc_sum[PHASE_W];
      if (issue) begin
        acc      <= acc_sum[PHASE_W-1:0];
        rom_addr <= acc[PHASE_W-1 -: ADDR_W] + phase;
        wave0    <= wave_sel;
      end
    end
  end

  // Stage 1: side-band delayed to line up with the ROM read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr1  <= '0;
      wave1  <= WAVE_SINE;
      valid1 <= 1'b0;
      wrap1  <= 1'b0;
    end else begin
      addr1  <= rom_addr;
      wave1  <= wave0;
      valid1 <= valid0;
      wrap1  <= wrap0;
    end
  end

  // Waveform shaping from the stage-1 address and ROM data.
  always_comb begin
    tri_full = {addr1[ADDR_W-2:0], 1'b0};
    if (addr1[ADDR_W-1]) tri_full = ~tri_full;
    shaped = rom_data;
    case (wave1)
      WAVE_SINE:   shaped = rom_data;
      WAVE_SQUARE: shaped = addr1[ADDR_W-1] ? '0 : '1;
      WAVE_TRI:    shaped = tri_full[ADDR_W-1 -: DATA_W];
      WAVE_SAW:    shaped = addr1[ADDR_W-1 -: DATA_W];
      default:     shaped = rom_data;
    endcase
  end

  // Stage 2: registered output sample, valid flag and wrap tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wave_data  <= '0;
      wave_valid <= 1'b0;
      cycle_tick <= 1'b0;
    end else begin
      wave_data  <= shaped;
      wave_valid <= valid1;
      cycle_tick <= wrap1;
    end
  end

endmodule

// File: tb/tb_dds_wave_gen.sv
// Directed bench for dds_wave_gen with a behavioural synchronous ROM.
module tb_dds_wave_gen;
  localparam int PHASE_W = 32;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 8;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b1;
  logic              en    = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] wave_data;
  logic              wave_valid;
  logic              cycle_tick;

  int checks   = 0;
  int failures = 0;

  dds_wave_gen_if #(.PHASE_W(PHASE_W), .ADDR_W(ADDR_W)) cfg_bus ();

  dds_wave_gen #(.PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .cfg        (cfg_bus),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .wave_data  (wave_data),
    .wave_valid (wave_valid),
    .cycle_tick (cycle_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] rom_fn(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ {6'b0, a[9:8]} ^ 8'hA5;
  endfunction

  // Synchronous ROM, one cycle of read latency.
  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic configure(input logic [PHASE_W-1:0] f, input logic [ADDR_W-1:0] p,
                           input logic [1:0] w);
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_freq  = f;
    cfg_bus.cfg_phase = p;
    cfg_bus.cfg_wave  = w;
    step();
    cfg_bus.cfg_valid = 1'b0;
  endtask

  int tick_cnt;
  int tick_at;
  logic [DATA_W-1:0] exp_tri;
  logic check_tri;

  initial begin
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_freq  = '0;
    cfg_bus.cfg_phase = '0;
    cfg_bus.cfg_wave  = '0;

    // Reset state, including cfg_ready held low through release.
    #1 rst_n = 1'b0;
    #2;
    check("rst rom_addr", rom_addr, 0);
    check("rst wave_data", wave_data, 0);
    check("rst wave_valid", wave_valid, 0);
    check("rst cycle_tick", cycle_tick, 0);
    check("rst cfg_ready", cfg_bus.cfg_ready, 0);
    step();
    step();
    check("rst cfg_ready clocked", cfg_bus.cfg_ready, 0);
    rst_n = 1'b1;
    #1;
    check("release cfg_ready", cfg_bus.cfg_ready, 0);
    step();
    check("first clk cfg_ready", cfg_bus.cfg_ready, 1);

    // Sine ramp through the whole table, one wrap tick per 1024 samples.
    configure(32'h0040_0000, 10'd0, 2'd0);
    en = 1'b1;
    tick_cnt = 0;
    tick_at  = -1;
    for (int n = 0; n <= 1100; n++) begin
      step();
      if (n < 6 || n == 1023 || n == 1024)
        check($sformatf("A addr n=%0d", n), rom_addr, n % 1024);
      if (n < 2) check($sformatf("A valid n=%0d", n), wave_valid, 0);
      if (n >= 2 && n < 6) begin
        check($sformatf("A valid n=%0d", n), wave_valid, 1);
        check($sformatf("A sine n=%0d", n), wave_data, rom_fn(10'(n - 2)));
      end
      if (cycle_tick) begin
        tick_cnt++;
        if (tick_at < 0) tick_at = n;
      end
    end
    check("A tick count", tick_cnt, 1);
    check("A tick pos", tick_at, 1025);

    // en drops while a sawtooth config is accepted on the same edge.
    en = 1'b0;
    configure(32'h0040_0000, 10'd0, 2'd3);
    check("D f0 cfg_ready", cfg_bus.cfg_ready, 0);
    check("D f0 valid", wave_valid, 1);
    check("D f0 addr held", rom_addr, 76);
    step();
    check("D f1 cfg_ready", cfg_bus.cfg_ready, 0);
    check("D f1 valid", wave_valid, 1);
    check("D f1 last sample", wave_data, rom_fn(10'd76));
    step();
    check("D f2 cfg_ready", cfg_bus.cfg_ready, 1);
    check("D f2 valid", wave_valid, 0);
    step();
    check("D idle addr", rom_addr, 76);
    en = 1'b1;
    step();
    check("D resume addr", rom_addr, 77);
    step();
    check("D r1 valid", wave_valid, 0);
    step();
    check("D r2 valid", wave_valid, 1);
    check("D r2 saw", wave_data, 8'h13);

    // Asynchronous reset mid-RUN clears outputs immediately.
    #3 rst_n = 1'b0;
    en = 1'b0;
    #1;
    check("M rom_addr", rom_addr, 0);
    check("M wave_data", wave_data, 0);
    check("M wave_valid", wave_valid, 0);
    check("M cycle_tick", cycle_tick, 0);
    check("M cfg_ready", cfg_bus.cfg_ready, 0);
    step();
    rst_n = 1'b1;
    step();

    // Half-rate square with a wrap on every second sample.
    configure(32'h8000_0000, 10'd0, 2'd1);
    en = 1'b1;
    for (int n = 0; n < 8; n++) begin
      step();
      check($sformatf("B addr n=%0d", n), rom_addr, (n % 2) ? 512 : 0);
      if (n >= 2) begin
        check($sformatf("B square n=%0d", n), wave_data, ((n - 2) % 2) ? 8'h00 : 8'hFF);
        check($sformatf("B tick n=%0d", n), cycle_tick, (n - 2) % 2);
      end else begin
        check($sformatf("B valid n=%0d", n), wave_valid, 0);
      end
    end

    // Phase offset 256: address wraps 1023 -> 0 cleanly.
    do_reset();
    configure(32'h0040_0000, 10'd256, 2'd0);
    en = 1'b1;
    for (int n = 0; n <= 770; n++) begin
      step();
      if (n <= 1 || (n >= 767 && n <= 770))
        check($sformatf("C addr n=%0d", n), rom_addr, (n + 256) % 1024);
      if (n == 2) check("C first sample", wave_data, rom_fn(10'd256));
      if (n == 769) check("C sample 1023", wave_data, rom_fn(10'd1023));
      if (n == 770) check("C sample 0", wave_data, rom_fn(10'd0));
    end

    // Triangle at selected addresses.
    do_reset();
    configure(32'h0040_0000, 10'd0, 2'd2);
    en = 1'b1;
    for (int n = 0; n <= 1025; n++) begin
      step();
      check_tri = 1'b1;
      case (n - 2)
        0:       exp_tri = 8'h00;
        127:     exp_tri = 8'h3F;
        256:     exp_tri = 8'h80;
        384:     exp_tri = 8'hC0;
        511:     exp_tri = 8'hFF;
        512:     exp_tri = 8'hFF;
        768:     exp_tri = 8'h7F;
        1023:    exp_tri = 8'h00;
        default: begin exp_tri = 8'h00; check_tri = 1'b0; end
      endcase
      if (check_tri) check($sformatf("E tri addr=%0d", n - 2), wave_data, exp_tri);
    end

    // Zero tuning word: fixed address, no wrap ticks.
    do_reset();
    configure(32'h0, 10'd5, 2'd0);
    en = 1'b1;
    tick_cnt = 0;
    for (int n = 0; n < 8; n++) begin
      step();
      if (cycle_tick) tick_cnt++;
      if (n == 0 || n == 7) check($sformatf("F addr n=%0d", n), rom_addr, 5);
    end
    check("F tick count", tick_cnt, 0);
    check("F sample", wave_data, rom_fn(10'd5));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
